// File: rtl/rv_pkg.sv
// Shared core definitions: datapath width, the decode bubble instruction and
// the fetch queue's {pc, instr} pairing.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Slot storage for the fetch queue: allocate writes the PC, fill writes the
// instruction, and the read port exposes the head slot.
module fetch_buf
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     alloc_en,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic                     fill_en,
  input  logic [$clog2(DEPTH)-1:0] fill_idx,
  input  logic [31:0]              fill_instr,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]          rd_pc,
  output logic [31:0]              rd_instr,
  output logic                     rd_filled
);

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [DEPTH-1:0] filled;

  // Alloc and fill never target the same slot: fill only lands on a slot
  // that was allocated in an earlier cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
      filled <= '0;
    end else begin
      if (alloc_en) begin
        pc_mem[alloc_idx] <= alloc_pc;
        filled[alloc_idx] <= 1'b0;
      end
      if (fill_en) begin
        instr_mem[fill_idx] <= fill_instr;
        filled[fill_idx]    <= 1'b1;
      end
    end
  end

  assign rd_pc     = pc_mem[rd_idx];
  assign rd_instr  = instr_mem[rd_idx];
  assign rd_filled = filled[rd_idx];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues pc_i to instruction memory, tracks in-order
// responses and hands {pc, instr} to decode; redirects discard stale fetches.
//
// Handshakes: imem request/grant transfers when imem_req_o && imem_gnt_i in
// the same cycle; decode transfers when id_valid_o && id_ready_i in the same
// cycle; neither valid side waits on its ready.
module fetch_queue
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_write_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_instr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] alloc_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0] occ, unfilled, drop_cnt;
  logic [CW:0]   inflight, drop_flush;
  logic          grant, pop, fill_en, drop_en, head_filled, rsp_owned;

  // Stale responses still occupy memory-side slots, so they count against room.
  assign inflight    = {1'b0, occ} + {1'b0, drop_cnt};
  assign imem_req_o  = reset_n && !flush_i && (inflight < (CW+1)'(DEPTH));
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o && imem_gnt_i;
  assign pc_write_o  = grant;

  assign id_valid_o  = !flush_i && (occ != '0) && head_filled;
  assign pop         = id_valid_o && id_ready_i;

  assign rsp_owned   = (drop_cnt != '0) || (unfilled != '0);
  assign drop_en     = imem_rvalid_i && (drop_cnt != '0);
  assign fill_en     = imem_rvalid_i && !flush_i && (drop_cnt == '0) && (unfilled != '0);

  // Everything still unfilled becomes stale; a response landing now is dropped.
  assign drop_flush  = {1'b0, drop_cnt} + {1'b0, unfilled}
                     - (CW+1)'(imem_rvalid_i && rsp_owned);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      unfilled  <= '0;
      drop_cnt  <= '0;
    end else if (flush_i) begin
      fill_ptr  <= alloc_ptr;
      rd_ptr    <= alloc_ptr;
      occ       <= '0;
      unfilled  <= '0;
      drop_cnt  <= drop_flush[CW-1:0];
    end else begin
      alloc_ptr <= alloc_ptr + AW'(grant);
      fill_ptr  <= fill_ptr + AW'(fill_en);
      rd_ptr    <= rd_ptr + AW'(pop);
      occ       <= occ + CW'(grant) - CW'(pop);
      unfilled  <= unfilled + CW'(grant) - CW'(fill_en);
      drop_cnt  <= drop_cnt - CW'(drop_en);
    end
  end

  fetch_buf #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .alloc_en   (grant),
    .alloc_idx  (alloc_ptr),
    .alloc_pc   (pc_i),
    .fill_en    (fill_en),
    .fill_idx   (fill_ptr),
    .fill_instr (imem_rdata_i),
    .rd_idx     (rd_ptr),
    .rd_pc      (id_pc_o),
    .rd_instr   (id_instr_o),
    .rd_filled  (head_filled)
  );

  // A response with nothing outstanding means the memory broke its contract.
  ap_no_orphan_rsp: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rvalid_i |-> rsp_owned);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory with variable latency, a pc register
// model, and a transaction-level reference of what decode must receive.
module tb_fetch_queue;
  import rv_pkg::*;

  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [XLEN-1:0] pc_i = '0;
  logic            pc_write_o;
  logic            flush_i = 1'b0;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i = 1'b0;
  logic            imem_rvalid_i = 1'b0;
  logic [31:0]     imem_rdata_i = '0;
  logic            id_valid_o;
  logic            id_ready_i = 1'b0;
  logic [XLEN-1:0] id_pc_o;
  logic [31:0]     id_instr_o;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_i          (pc_i),
    .pc_write_o    (pc_write_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct {
    fetch_entry_t ent;
    bit           filled;
  } model_t;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              epoch;
    int              due;
  } mem_req_t;

  model_t          exp_q[$];
  mem_req_t        mem_q[$];
  int              cycle, epoch, last_due;
  int              lat_min, lat_max, gnt_pct, rdy_pct, flush_pct;
  logic [XLEN-1:0] pc_reg;
  int              checks, errors;
  int              valid_cnt, grant_cnt;
  bit              await_first;
  logic [XLEN-1:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_id_valid", id_valid_o, 0);
    check("rst_imem_req", imem_req_o, 0);
    check("rst_pc_write", pc_write_o, 0);
    check("rst_id_pc", id_pc_o, 0);
    check("rst_id_instr", id_instr_o, 0);
    flush_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    id_ready_i = 1'b0; imem_rdata_i = '0; pc_i = '0;
    exp_q.delete();
    mem_q.delete();
    pc_reg = '0;
    epoch++;
    last_due = -1;
    await_first = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input bit force_flush, input logic [XLEN-1:0] tgt);
    bit       fl, g, r, exp_req, exp_valid, grant_dut;
    int       live, stale, fi, lat, due;
    mem_req_t m;
    model_t   nm;

    @(posedge clk);
    #1;
    fl = force_flush || ($urandom_range(99) < flush_pct);
    g  = $urandom_range(99) < gnt_pct;
    r  = $urandom_range(99) < rdy_pct;
    pc_i = pc_reg;
    flush_i = fl;
    imem_gnt_i = g;
    id_ready_i = r;
    if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end

    @(negedge clk);
    live  = exp_q.size();
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    exp_req   = !fl && (live + stale < DEPTH);
    exp_valid = !fl && live > 0 && exp_q[0].filled;
    check("imem_req", imem_req_o, exp_req);
    check("pc_write", pc_write_o, exp_req && g);
    check("imem_addr", imem_addr_o, pc_reg);
    check("id_valid", id_valid_o, exp_valid);
    if (exp_valid) begin
      check("id_pc", id_pc_o, exp_q[0].ent.pc);
      check("id_instr", id_instr_o, exp_q[0].ent.instr);
    end
    if (id_valid_o) valid_cnt++;
    if (await_first && id_valid_o) begin
      first_pc    = id_pc_o;
      await_first = 0;
    end

    grant_dut = imem_req_o && g;
    if (grant_dut) grant_cnt++;

    // The oldest unfilled live fetch takes a current-epoch response.
    if (imem_rvalid_i) begin
      m = mem_q.pop_front();
      if (!fl && m.epoch == epoch) begin
        fi = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (fi < 0 && !exp_q[i].filled) fi = i;
        if (fi >= 0) begin
          exp_q[fi].filled    = 1;
          exp_q[fi].ent.instr = mem_word(exp_q[fi].ent.pc);
        end
      end
    end
    if (exp_valid && r) void'(exp_q.pop_front());
    if (exp_req && g) begin
      nm.ent.pc    = pc_reg;
      nm.ent.instr = '0;
      nm.filled    = 0;
      exp_q.push_back(nm);
    end

    if (grant_dut) begin
      lat = $urandom_range(lat_max, lat_min);
      due = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
      m.addr  = pc_reg;
      m.epoch = epoch;
      m.due   = due;
      mem_q.push_back(m);
      last_due = due;
    end

    if (fl) begin
      exp_q.delete();
      epoch++;
      pc_reg = tgt;
      await_first = 1;
      first_pc = '1;
    end else if (pc_write_o) begin
      pc_reg = pc_reg + 4;
    end
    cycle++;
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int gp, input int rp, input int fp);
    lat_min = lmin; lat_max = lmax; gnt_pct = gp; rdy_pct = rp; flush_pct = fp;
  endtask

  // ---------------- sequence ----------------
  initial begin
    checks = 0; errors = 0; cycle = 0; epoch = 0; last_due = -1;
    pc_reg = '0; first_pc = '1; await_first = 0;
    set_knobs(1, 1, 100, 100, 0);

    // Reset, first fetch and full-throughput stream.
    do_reset();
    valid_cnt = 0;
    repeat (14) step(0, '0);
    check("stream_valid_cycles", valid_cnt, 12);

    // Backpressure: only DEPTH grants, then drain and resume at 0x10.
    do_reset();
    set_knobs(1, 1, 100, 0, 0);
    grant_cnt = 0;
    repeat (8) step(0, '0);
    check("backpressure_grants", grant_cnt, 4);
    set_knobs(1, 1, 100, 100, 0);
    repeat (10) step(0, '0);

    // Flush with in-flight responses at 3-cycle latency.
    do_reset();
    set_knobs(3, 3, 100, 100, 0);
    repeat (3) step(0, '0);
    step(1, 32'h100);
    repeat (10) step(0, '0);
    check("flush_first_pc", first_pc, 32'h100);

    // Flush coinciding with a response.
    set_knobs(1, 1, 100, 100, 0);
    repeat (6) step(0, '0);
    step(1, 32'h200);
    repeat (8) step(0, '0);
    check("flush_rvalid_first_pc", first_pc, 32'h200);

    // Randomized traffic with sporadic redirects.
    set_knobs(1, 4, 70, 60, 4);
    for (int n = 0; n < 3000; n++) step(0, {22'h0, 8'($urandom_range(255)), 2'b00});

    // Fill the buffer, then reset asynchronously mid-cycle.
    set_knobs(1, 1, 100, 0, 0);
    repeat (6) step(0, '0);
    do_reset();
    set_knobs(1, 2, 100, 100, 0);
    repeat (10) step(0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage sitting directly downstream of `pc`. Each cycle it may issue the current PC to instruction memory, track the in-order response, and buffer `{pc, instr}` pairs for decode behind a valid/ready handshake. It generates the sequential-advance enable for `pc` and discards stale fetches on a branch/jump redirect.

## Interface

**Parameters**
- `XLEN`, default 32: address and instruction width.
- `DEPTH`, default 4: buffer entries; power of two, minimum 2.

**Ports**
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pc_i` in XLEN: current PC from `pc`.
- `pc_write_o` out 1: sequential-advance enable. Top level drives `pc.pcWrite = pc_write_o | flush_i`.
- `flush_i` in 1: redirect from EX (`branch_taken | jump`).
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out XLEN: fetch address, equal to `pc_i`.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response valid. Exactly one response per grant, in order, arriving 1 or more cycles after the grant.
- `imem_rdata_i` in 32: instruction word.
- `id_valid_o` out 1: head entry holds a valid instruction.
- `id_ready_i` in 1: decode accepts.
- `id_pc_o` out XLEN: PC of the head entry.
- `id_instr_o` out 32: instruction of the head entry.

## Operation

**Buffer**
- DEPTH slots, each holding `pc`, `instr` and a `filled` bit.
- Three pointers, each `$clog2(DEPTH)` bits and wrapping modulo DEPTH: `alloc_ptr`, `fill_ptr`, `rd_ptr`.
- `occ` (0..DEPTH) counts allocated entries not yet popped.
- `drop_cnt` (0..DEPTH) counts outstanding responses to be discarded.

**Issue**
- `imem_req_o = !flush_i && (occ + drop_cnt < DEPTH)`.
- On `imem_req_o && imem_gnt_i`: write `pc_i` into slot `alloc_ptr`, clear its `filled` bit, increment `alloc_ptr`.
- `pc_write_o = imem_req_o && imem_gnt_i`, so the PC advances only on an accepted fetch.

**Response**
- On `imem_rvalid_i` with `drop_cnt > 0`: discard the data and decrement `drop_cnt`.
- Otherwise: write `imem_rdata_i` into slot `fill_ptr`, set its `filled` bit, increment `fill_ptr`.
- `imem_rvalid_i` with no allocated unfilled entry and `drop_cnt == 0` is a protocol error. Assert it in simulation; the RTL ignores it.

**Pop**
- `id_valid_o = occ != 0 && slot[rd_ptr].filled`.
- `id_pc_o` and `id_instr_o` are driven from slot `rd_ptr`.
- On `id_valid_o && id_ready_i`: increment `rd_ptr`.

**Concurrency**
- Allocation, fill and pop in the same cycle are all legal.
- `occ` next = `occ` + grant − pop.

**Flush**
- In the `flush_i` cycle: no request is issued and no pop is taken (`id_valid_o` is forced low).
- At the clock edge:
  - `occ` ← 0.
  - All pointers ← `alloc_ptr` value.
  - `drop_cnt` ← `drop_cnt` + (allocated-unfilled count) − (`imem_rvalid_i` ? 1 : 0).
- A response arriving in the flush cycle is dropped.
- Issue resumes the next cycle using the redirected `pc_i`.

## Timing

**Reset values:** all pointers 0, `occ` 0, `drop_cnt` 0, all `filled` bits 0, `id_valid_o` 0, `imem_req_o` 0, `pc_write_o` 0, `id_pc_o`/`id_instr_o` 0.

**Combinational paths:** `imem_req_o`, `imem_addr_o` and `pc_write_o` are combinational from state, `pc_i` and `flush_i`. There is no path from `imem_rdata_i` to any output.

**Latency:** grant in cycle N, `rvalid` in N+1, `id_valid_o` high in N+2.

**Throughput:** with 1-cycle memory latency and `id_ready_i` held high, DEPTH=4 sustains one fetch per cycle.

**Boundaries:**
- Full (`occ + drop_cnt == DEPTH`): `imem_req_o` low, PC held.
- Empty: `id_valid_o` low.
- Pointer wrap: pointers wrap from DEPTH−1 to 0.

**Reset:** reset asserted mid-operation clears all state immediately. Responses still in flight are the memory's responsibility; the memory is reset together with this block.

## Structure

**Shared `rv_pkg`:**
- `XLEN`.
- `NOP_INSTR = 32'h0000_0013`, used by decode on bubbles.
- `fetch_entry_t` struct `{pc, instr}`.

**Sub-module:** `fetch_buf` holds the slot storage with independent alloc, fill and read ports. `fetch_queue` owns the counters, drop logic and handshake.

## Test plan

- **Reset and first fetch:** `reset_n` low then high, `pc_i`=0x0, gnt=1, 1-cycle memory → `imem_req_o`=1 in the first cycle; `id_valid_o` high 2 cycles later with `id_pc_o`=0x0 and the instruction at 0x0.
- **Full-throughput stream:** `pc_i` 0x0,0x4,0x8,…, `id_ready_i`=1 → `id_valid_o` high every cycle from cycle 2; ten consecutive instructions in order with matching PCs.
- **Backpressure:** `id_ready_i`=0 for 8 cycles → exactly 4 grants, then `imem_req_o`=0 and `pc_write_o`=0; releasing `id_ready_i` drains 0x0..0xC in order, then fetch resumes at 0x10.
- **Flush with in-flight data:** 3-cycle memory latency, 2 outstanding requests, `flush_i` pulse with `pc_i`→0x100 → both stale responses discarded; the next `id_valid_o` carries `id_pc_o`=0x100.
- **Simultaneous flush and rvalid:** `rvalid` in the flush cycle → data dropped, `drop_cnt` correct, no stale instruction reaches decode.
- **Async reset mid-stream:** `reset_n` low mid-cycle with full buffer → `id_valid_o`=0 immediately and all state at reset values.
